id_ex_reg: RTL and testbench
============================

// Module: id_ex_reg
// PURPOSE
//  ID/EX pipeline latch of the 5-stage MIPS core. Captures decoded operands, register addresses,
//  immediate and control word from ID and presents them to EX, where the forwarding muxes select
//  between o_rs_data/o_rt_data and the EX/MEM and MEM/WB results. Supports debug freeze, stall hold,
//  flush (bubble insertion) and same-cycle WB->ID operand bypass.
// PARAMETERS
//  NB        32  data/PC/immediate width
//  NB_ADDR    5  register address width
//  NB_ALUOP   6  ALU operation code width
//  NB_SEL     2  width of reg_dst and mem_to_reg selects (drive 4-input muxes)
// PORTS
//  i_clock         in   1         rising-edge clock
//  i_reset_n       in   1         asynchronous active-low reset
//  i_enable        in   1         global pipeline enable (debug unit); 0 freezes the latch
//  i_stall         in   1         hazard unit: hold current contents
//  i_flush         in   1         hazard/branch unit: load a bubble
//  i_pc_plus4      in   NB        PC+4 of instruction in ID
//  i_rs_data       in   NB        register file read port A
//  i_rt_data       in   NB        register file read port B
//  i_imm           in   NB        sign/zero-extended immediate
//  i_rs_addr       in   NB_ADDR   rs field
//  i_rt_addr       in   NB_ADDR   rt field
//  i_rd_addr       in   NB_ADDR   rd field
//  i_alu_op        in   NB_ALUOP  ALU operation
//  i_alu_src       in   1         0 = rt_data, 1 = imm
//  i_reg_dst       in   NB_SEL    destination select (rt / rd / r31)
//  i_mem_to_reg    in   NB_SEL    WB source select (alu / mem / pc+4)
//  i_reg_write     in   1         control: writes register file
//  i_mem_read      in   1         control: load
//  i_mem_write     in   1         control: store
//  i_wb_reg_write  in   1         WB stage write enable (bypass)
//  i_wb_addr       in   NB_ADDR   WB stage destination
//  i_wb_data       in   NB        WB stage write data
//  o_*             out  (same)    registered copy of every i_* field above except i_enable,
//                                 i_stall, i_flush and i_wb_*
//  o_valid         out  1         1 = slot holds a real instruction, 0 = bubble
// BEHAVIOUR
//  - Reset (i_reset_n=0, async, no clock needed): all outputs 0, o_valid=0. Release synchronous to
//    next edge; first load occurs on the first rising edge with i_reset_n=1 and i_enable=1.
//  - Per rising edge, priority: i_enable=0 -> hold all; else i_flush=1 -> bubble; else i_stall=1 ->
//    hold all; else load. Flush wins over stall in the same cycle.
//  - Load: every o_* <= i_*, o_valid <= 1. Latency exactly 1 cycle.
//  - Bubble: o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_valid <= 0; o_alu_op, o_reg_dst,
//    o_mem_to_reg <= 0; data/address fields <= 0. A bubble must never write register or memory.
//  - WB bypass on load only: if i_wb_reg_write=1 and i_wb_addr!=0 and i_wb_addr==i_rs_addr then
//    o_rs_data <= i_wb_data (same independently for rt). Register 0 is never bypassed.
//    Bypass does not apply during hold or bubble.
//  - No combinational path input->output; all outputs come directly from flops.
//  - Reset asserted mid-operation clears contents immediately regardless of i_enable/i_stall.
// TESTING
//  1 Reset: drive all inputs nonzero, i_reset_n=0 -> all outputs 0 without a clock edge; o_valid=0.
//  2 Load: i_rs_data=32'h1234, i_rd_addr=5'd7, i_reg_write=1, one edge -> o_rs_data=32'h1234,
//    o_rd_addr=7, o_reg_write=1, o_valid=1.
//  3 Stall+flush: stall=1 for 3 edges with changing inputs -> outputs frozen; stall=1,flush=1 ->
//    o_valid=0, o_reg_write=0, o_mem_write=0.
//  4 Freeze: i_enable=0, i_flush=1 -> nothing changes; i_enable=1 -> bubble on that edge.
//  5 Bypass: i_rs_addr=5'd3, i_wb_addr=5'd3, i_wb_reg_write=1, i_wb_data=32'hDEAD, i_rs_data=0 ->
//    o_rs_data=32'hDEAD; repeat with addr 0 and wb_data=32'hBEEF -> o_rs_data=i_rs_data.
//  6 Async reset mid-stall: assert i_reset_n=0 between edges while stalled -> outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg -- ID/EX pipeline latch of the 5-stage MIPS core.
//
// Captures the decoded operands, register addresses, immediate and control
// word produced in ID and presents them to EX. EX forwarding muxes choose
// between o_rs_data/o_rt_data and the EX/MEM and MEM/WB results.
//
// Per rising edge, in priority order:
//   i_enable = 0  -> hold everything (debug freeze)
//   i_flush  = 1  -> load a bubble (all fields zero, o_valid = 0)
//   i_stall  = 1  -> hold everything
//   otherwise     -> load the ID fields, o_valid = 1
//
// While loading, a WB-stage write that targets rs or rt (and is not r0) is
// bypassed into the captured operand, because the register file read in ID
// happens in the same cycle as that write and would return the stale value.
//
// Ports
//   i_clock, i_reset_n        clock, asynchronous active-low reset
//   i_enable, i_stall, i_flush pipeline control (see priority above)
//   i_pc_plus4 .. i_mem_write  ID-stage fields, registered to o_* copies
//   i_wb_reg_write/addr/data   WB-stage write port, used for the bypass
//   o_* (same widths)          registered copies of the ID-stage fields
//   o_valid                    1 = real instruction, 0 = bubble
//
// Every output is driven straight from a flop; there is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module id_ex_reg #(
  parameter int unsigned NB       = 32,
  parameter int unsigned NB_ADDR  = 5,
  parameter int unsigned NB_ALUOP = 6,
  parameter int unsigned NB_SEL   = 2
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic [NB-1:0]       i_pc_plus4,
  input  logic [NB-1:0]       i_rs_data,
  input  logic [NB-1:0]       i_rt_data,
  input  logic [NB-1:0]       i_imm,
  input  logic [NB_ADDR-1:0]  i_rs_addr,
  input  logic [NB_ADDR-1:0]  i_rt_addr,
  input  logic [NB_ADDR-1:0]  i_rd_addr,
  input  logic [NB_ALUOP-1:0] i_alu_op,
  input  logic                i_alu_src,
  input  logic [NB_SEL-1:0]   i_reg_dst,
  input  logic [NB_SEL-1:0]   i_mem_to_reg,
  input  logic                i_reg_write,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic                i_wb_reg_write,
  input  logic [NB_ADDR-1:0]  i_wb_addr,
  input  logic [NB-1:0]       i_wb_data,
  output logic [NB-1:0]       o_pc_plus4,
  output logic [NB-1:0]       o_rs_data,
  output logic [NB-1:0]       o_rt_data,
  output logic [NB-1:0]       o_imm,
  output logic [NB_ADDR-1:0]  o_rs_addr,
  output logic [NB_ADDR-1:0]  o_rt_addr,
  output logic [NB_ADDR-1:0]  o_rd_addr,
  output logic [NB_ALUOP-1:0] o_alu_op,
  output logic                o_alu_src,
  output logic [NB_SEL-1:0]   o_reg_dst,
  output logic [NB_SEL-1:0]   o_mem_to_reg,
  output logic                o_reg_write,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_valid
);

  // One pipeline slot. An all-zero slot is by construction a bubble: no
  // register write, no memory access, o_valid = 0.
  typedef struct packed {
    logic [NB-1:0]       pc_plus4;
    logic [NB-1:0]       rs_data;
    logic [NB-1:0]       rt_data;
    logic [NB-1:0]       imm;
    logic [NB_ADDR-1:0]  rs_addr;
    logic [NB_ADDR-1:0]  rt_addr;
    logic [NB_ADDR-1:0]  rd_addr;
    logic [NB_ALUOP-1:0] alu_op;
    logic                alu_src;
    logic [NB_SEL-1:0]   reg_dst;
    logic [NB_SEL-1:0]   mem_to_reg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                valid;
  } slot_t;

  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_LOAD   = 2'd2
  } action_t;

  slot_t   slot_q;
  slot_t   slot_d;
  slot_t   load_slot;
  action_t action;
  logic    rs_hit;
  logic    rt_hit;

  // WB bypass hit detection. r0 is hard-wired to zero in the register file,
  // so a WB "write" to r0 must never leak into an operand.
  assign rs_hit = i_wb_reg_write && (i_wb_addr != '0) && (i_wb_addr == i_rs_addr);
  assign rt_hit = i_wb_reg_write && (i_wb_addr != '0) && (i_wb_addr == i_rt_addr);

  // Slot contents used when the latch loads a new instruction.
  always_comb begin
    // NOTE: every variable written in an always_comb gets a value on entry;
    // a path that leaves one unassigned would infer a latch.
    load_slot            = '0;
    load_slot.pc_plus4   = i_pc_plus4;
    load_slot.rs_data    = rs_hit ? i_wb_data : i_rs_data;
    load_slot.rt_data    = rt_hit ? i_wb_data : i_rt_data;
    load_slot.imm        = i_imm;
    load_slot.rs_addr    = i_rs_addr;
    load_slot.rt_addr    = i_rt_addr;
    load_slot.rd_addr    = i_rd_addr;
    load_slot.alu_op     = i_alu_op;
    load_slot.alu_src    = i_alu_src;
    load_slot.reg_dst    = i_reg_dst;
    load_slot.mem_to_reg = i_mem_to_reg;
    load_slot.reg_write  = i_reg_write;
    load_slot.mem_read   = i_mem_read;
    load_slot.mem_write  = i_mem_write;
    load_slot.valid      = 1'b1;
  end

  // Action decode. The debug freeze outranks everything so that the debug
  // unit can single-step without a pending flush being consumed early; flush
  // outranks stall so a squashed instruction cannot linger in the slot.
  always_comb begin
    action = ACT_LOAD;
    if (!i_enable) begin
      action = ACT_HOLD;
    end else if (i_flush) begin
      action = ACT_BUBBLE;
    end else if (i_stall) begin
      action = ACT_HOLD;
    end
  end

  always_comb begin
    slot_d = slot_q;
    unique case (action)
      ACT_HOLD:   slot_d = slot_q;
      ACT_BUBBLE: slot_d = '0;
      ACT_LOAD:   slot_d = load_slot;
      default:    slot_d = slot_q;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!i_reset_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign o_pc_plus4   = slot_q.pc_plus4;
  assign o_rs_data    = slot_q.rs_data;
  assign o_rt_data    = slot_q.rt_data;
  assign o_imm        = slot_q.imm;
  assign o_rs_addr    = slot_q.rs_addr;
  assign o_rt_addr    = slot_q.rt_addr;
  assign o_rd_addr    = slot_q.rd_addr;
  assign o_alu_op     = slot_q.alu_op;
  assign o_alu_src    = slot_q.alu_src;
  assign o_reg_dst    = slot_q.reg_dst;
  assign o_mem_to_reg = slot_q.mem_to_reg;
  assign o_reg_write  = slot_q.reg_write;
  assign o_mem_read   = slot_q.mem_read;
  assign o_mem_write  = slot_q.mem_write;
  assign o_valid      = slot_q.valid;

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg -- directed self-checking bench for id_ex_reg.
// Each scenario task drives stimulus and compares the registered outputs with
// hand-written expected slots. Outputs are sampled 1 time unit after the
// rising edge; inputs are changed at that same point, well before the next
// edge.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

  localparam int NB       = 32;
  localparam int NB_ADDR  = 5;
  localparam int NB_ALUOP = 6;
  localparam int NB_SEL   = 2;

  typedef struct packed {
    logic [NB-1:0]       pc_plus4;
    logic [NB-1:0]       rs_data;
    logic [NB-1:0]       rt_data;
    logic [NB-1:0]       imm;
    logic [NB_ADDR-1:0]  rs_addr;
    logic [NB_ADDR-1:0]  rt_addr;
    logic [NB_ADDR-1:0]  rd_addr;
    logic [NB_ALUOP-1:0] alu_op;
    logic                alu_src;
    logic [NB_SEL-1:0]   reg_dst;
    logic [NB_SEL-1:0]   mem_to_reg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                valid;
  } slot_t;

  logic                i_clock = 1'b0;
  logic                i_reset_n;
  logic                i_enable;
  logic                i_stall;
  logic                i_flush;
  logic [NB-1:0]       i_pc_plus4;
  logic [NB-1:0]       i_rs_data;
  logic [NB-1:0]       i_rt_data;
  logic [NB-1:0]       i_imm;
  logic [NB_ADDR-1:0]  i_rs_addr;
  logic [NB_ADDR-1:0]  i_rt_addr;
  logic [NB_ADDR-1:0]  i_rd_addr;
  logic [NB_ALUOP-1:0] i_alu_op;
  logic                i_alu_src;
  logic [NB_SEL-1:0]   i_reg_dst;
  logic [NB_SEL-1:0]   i_mem_to_reg;
  logic                i_reg_write;
  logic                i_mem_read;
  logic                i_mem_write;
  logic                i_wb_reg_write;
  logic [NB_ADDR-1:0]  i_wb_addr;
  logic [NB-1:0]       i_wb_data;
  logic [NB-1:0]       o_pc_plus4;
  logic [NB-1:0]       o_rs_data;
  logic [NB-1:0]       o_rt_data;
  logic [NB-1:0]       o_imm;
  logic [NB_ADDR-1:0]  o_rs_addr;
  logic [NB_ADDR-1:0]  o_rt_addr;
  logic [NB_ADDR-1:0]  o_rd_addr;
  logic [NB_ALUOP-1:0] o_alu_op;
  logic                o_alu_src;
  logic [NB_SEL-1:0]   o_reg_dst;
  logic [NB_SEL-1:0]   o_mem_to_reg;
  logic                o_reg_write;
  logic                o_mem_read;
  logic                o_mem_write;
  logic                o_valid;

  slot_t obs;
  assign obs = {o_pc_plus4, o_rs_data, o_rt_data, o_imm, o_rs_addr, o_rt_addr,
                o_rd_addr, o_alu_op, o_alu_src, o_reg_dst, o_mem_to_reg,
                o_reg_write, o_mem_read, o_mem_write, o_valid};

  int n_total = 0;
  int n_pass  = 0;

  slot_t pat_a, pat_b, pat_c, p, e;

  id_ex_reg #(.NB(NB), .NB_ADDR(NB_ADDR), .NB_ALUOP(NB_ALUOP), .NB_SEL(NB_SEL)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_stall(i_stall), .i_flush(i_flush),
    .i_pc_plus4(i_pc_plus4), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_imm(i_imm), .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
    .i_rd_addr(i_rd_addr), .i_alu_op(i_alu_op), .i_alu_src(i_alu_src),
    .i_reg_dst(i_reg_dst), .i_mem_to_reg(i_mem_to_reg),
    .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_wb_reg_write(i_wb_reg_write), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_pc_plus4(o_pc_plus4), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_imm(o_imm), .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr),
    .o_rd_addr(o_rd_addr), .o_alu_op(o_alu_op), .o_alu_src(o_alu_src),
    .o_reg_dst(o_reg_dst), .o_mem_to_reg(o_mem_to_reg),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_valid(o_valid)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Drive the ID-stage fields from a slot (its valid bit is not an input).
  task automatic drive(input slot_t v);
    i_pc_plus4   = v.pc_plus4;
    i_rs_data    = v.rs_data;
    i_rt_data    = v.rt_data;
    i_imm        = v.imm;
    i_rs_addr    = v.rs_addr;
    i_rt_addr    = v.rt_addr;
    i_rd_addr    = v.rd_addr;
    i_alu_op     = v.alu_op;
    i_alu_src    = v.alu_src;
    i_reg_dst    = v.reg_dst;
    i_mem_to_reg = v.mem_to_reg;
    i_reg_write  = v.reg_write;
    i_mem_read   = v.mem_read;
    i_mem_write  = v.mem_write;
  endtask

  task automatic ctrl(input logic en, input logic st, input logic fl);
    i_enable = en;
    i_stall  = st;
    i_flush  = fl;
  endtask

  task automatic wb(input logic we, input logic [NB_ADDR-1:0] a, input logic [NB-1:0] d);
    i_wb_reg_write = we;
    i_wb_addr      = a;
    i_wb_data      = d;
  endtask

  task automatic test_reset();
    // Everything nonzero, then reset between edges.
    ctrl(1'b1, 1'b1, 1'b1);
    wb(1'b1, 5'd2, 32'hAAAA_5555);
    drive(pat_b);
    #2;
    i_reset_n = 1'b0;
    #1;
    n_total++; if (obs !== '0) $display("FAIL reset_async_all: got %h want 0", obs); else n_pass++;
    n_total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else n_pass++;
    tick();
    n_total++; if (obs !== '0) $display("FAIL reset_held_over_edge: got %h want 0", obs); else n_pass++;
    i_reset_n = 1'b1;
    ctrl(1'b1, 1'b0, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_load();
    p = pat_a;
    drive(p);
    tick();
    n_total++; if (obs !== pat_a) $display("FAIL load_all: got %h want %h", obs, pat_a); else n_pass++;
    n_total++; if (o_rs_data !== 32'h1234) $display("FAIL load_rs_data: got %h want 1234", o_rs_data); else n_pass++;
    n_total++; if (o_rd_addr !== 5'd7) $display("FAIL load_rd_addr: got %0d want 7", o_rd_addr); else n_pass++;
    n_total++; if (o_reg_write !== 1'b1) $display("FAIL load_reg_write: got %b want 1", o_reg_write); else n_pass++;
    n_total++; if (o_valid !== 1'b1) $display("FAIL load_valid: got %b want 1", o_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(pat_b);
    tick();
    n_total++; if (obs !== pat_b) $display("FAIL b2b_first: got %h want %h", obs, pat_b); else n_pass++;
    drive(pat_c);
    tick();
    n_total++; if (obs !== pat_c) $display("FAIL b2b_second: got %h want %h", obs, pat_c); else n_pass++;
  endtask

  task automatic test_stall_flush();
    // Slot currently holds pat_c.
    ctrl(1'b1, 1'b1, 1'b0);
    drive(pat_a); tick();
    n_total++; if (obs !== pat_c) $display("FAIL stall_hold_1: got %h want %h", obs, pat_c); else n_pass++;
    drive(pat_b); tick();
    n_total++; if (obs !== pat_c) $display("FAIL stall_hold_2: got %h want %h", obs, pat_c); else n_pass++;
    drive(pat_a); tick();
    n_total++; if (obs !== pat_c) $display("FAIL stall_hold_3: got %h want %h", obs, pat_c); else n_pass++;
    ctrl(1'b1, 1'b1, 1'b1);
    tick();
    n_total++; if (obs !== '0) $display("FAIL flush_over_stall_all: got %h want 0", obs); else n_pass++;
    n_total++; if (o_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", o_valid); else n_pass++;
    n_total++; if (o_reg_write !== 1'b0) $display("FAIL flush_reg_write: got %b want 0", o_reg_write); else n_pass++;
    n_total++; if (o_mem_write !== 1'b0) $display("FAIL flush_mem_write: got %b want 0", o_mem_write); else n_pass++;
    ctrl(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_freeze();
    drive(pat_a); tick();
    n_total++; if (obs !== pat_a) $display("FAIL freeze_preload: got %h want %h", obs, pat_a); else n_pass++;
    ctrl(1'b0, 1'b0, 1'b1);
    drive(pat_b); tick();
    n_total++; if (obs !== pat_a) $display("FAIL freeze_flush_1: got %h want %h", obs, pat_a); else n_pass++;
    tick();
    n_total++; if (obs !== pat_a) $display("FAIL freeze_flush_2: got %h want %h", obs, pat_a); else n_pass++;
    ctrl(1'b1, 1'b0, 1'b1);
    tick();
    n_total++; if (obs !== '0) $display("FAIL unfreeze_bubble: got %h want 0", obs); else n_pass++;
    ctrl(1'b0, 1'b0, 1'b0);
    tick();
    n_total++; if (obs !== '0) $display("FAIL freeze_no_load: got %h want 0", obs); else n_pass++;
    ctrl(1'b1, 1'b0, 1'b0);
    tick();
    n_total++; if (obs !== pat_b) $display("FAIL unfreeze_load: got %h want %h", obs, pat_b); else n_pass++;
  endtask

  task automatic test_bypass();
    // rs hit.
    p = pat_a; p.rs_addr = 5'd3; p.rs_data = 32'h0;
    drive(p); wb(1'b1, 5'd3, 32'hDEAD);
    tick();
    n_total++; if (o_rs_data !== 32'hDEAD) $display("FAIL bypass_rs: got %h want dead", o_rs_data); else n_pass++;
    n_total++; if (o_rt_data !== 32'h5678) $display("FAIL bypass_rt_untouched: got %h want 5678", o_rt_data); else n_pass++;
    // r0 never bypassed.
    p = pat_a; p.rs_addr = 5'd0; p.rs_data = 32'h0;
    drive(p); wb(1'b1, 5'd0, 32'hBEEF);
    tick();
    n_total++; if (o_rs_data !== 32'h0) $display("FAIL bypass_r0: got %h want 0", o_rs_data); else n_pass++;
    // rt hit, rs miss.
    p = pat_a; p.rs_addr = 5'd4; p.rs_data = 32'h44; p.rt_addr = 5'd9; p.rt_data = 32'h5;
    drive(p); wb(1'b1, 5'd9, 32'hCAFE);
    tick();
    n_total++; if (o_rt_data !== 32'hCAFE) $display("FAIL bypass_rt: got %h want cafe", o_rt_data); else n_pass++;
    n_total++; if (o_rs_data !== 32'h44) $display("FAIL bypass_rs_miss: got %h want 44", o_rs_data); else n_pass++;
    // Write enable low: no bypass.
    wb(1'b0, 5'd9, 32'hCAFE);
    tick();
    n_total++; if (o_rt_data !== 32'h5) $display("FAIL bypass_we_low: got %h want 5", o_rt_data); else n_pass++;
    // Both operands read the WB destination.
    p = pat_a; p.rs_addr = 5'd12; p.rt_addr = 5'd12; p.rs_data = 32'h1; p.rt_data = 32'h2;
    drive(p); wb(1'b1, 5'd12, 32'h0BAD_F00D);
    tick();
    e = p; e.rs_data = 32'h0BAD_F00D; e.rt_data = 32'h0BAD_F00D;
    n_total++; if (obs !== e) $display("FAIL bypass_both: got %h want %h", obs, e); else n_pass++;
    // Stall with a matching WB write holds the old operand.
    p.rs_data = 32'h3; p.rt_data = 32'h4;
    drive(p); wb(1'b1, 5'd12, 32'h7777_7777);
    ctrl(1'b1, 1'b1, 1'b0);
    tick();
    n_total++; if (obs !== e) $display("FAIL bypass_during_stall: got %h want %h", obs, e); else n_pass++;
    // Flush with a matching WB write still yields a clean bubble.
    ctrl(1'b1, 1'b0, 1'b1);
    tick();
    n_total++; if (obs !== '0) $display("FAIL bypass_during_flush: got %h want 0", obs); else n_pass++;
    ctrl(1'b1, 1'b0, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_async_reset_mid_stall();
    drive(pat_c); tick();
    n_total++; if (obs !== pat_c) $display("FAIL mid_preload: got %h want %h", obs, pat_c); else n_pass++;
    ctrl(1'b1, 1'b1, 1'b0);
    drive(pat_a); tick();
    #2;
    i_reset_n = 1'b0;
    #1;
    n_total++; if (obs !== '0) $display("FAIL mid_stall_reset: got %h want 0", obs); else n_pass++;
    @(negedge i_clock);
    i_reset_n = 1'b1;
    tick();
    n_total++; if (obs !== '0) $display("FAIL post_reset_stall_hold: got %h want 0", obs); else n_pass++;
    ctrl(1'b1, 1'b0, 1'b0);
    tick();
    n_total++; if (obs !== pat_a) $display("FAIL post_reset_load: got %h want %h", obs, pat_a); else n_pass++;
  endtask

  initial begin
    pat_a = '{pc_plus4: 32'h0000_0104, rs_data: 32'h0000_1234, rt_data: 32'h0000_5678,
              imm: 32'hFFFF_FFF0, rs_addr: 5'd1, rt_addr: 5'd2, rd_addr: 5'd7,
              alu_op: 6'h21, alu_src: 1'b1, reg_dst: 2'b01, mem_to_reg: 2'b10,
              reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b1, valid: 1'b1};
    pat_b = '{pc_plus4: 32'h8000_0010, rs_data: 32'hA5A5_A5A5, rt_data: 32'h5A5A_5A5A,
              imm: 32'h0000_7FFF, rs_addr: 5'd31, rt_addr: 5'd30, rd_addr: 5'd29,
              alu_op: 6'h3F, alu_src: 1'b0, reg_dst: 2'b10, mem_to_reg: 2'b01,
              reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0, valid: 1'b1};
    pat_c = '{pc_plus4: 32'h0040_0000, rs_data: 32'h0000_0001, rt_data: 32'hFFFF_FFFF,
              imm: 32'h0000_0000, rs_addr: 5'd5, rt_addr: 5'd6, rd_addr: 5'd0,
              alu_op: 6'h01, alu_src: 1'b1, reg_dst: 2'b11, mem_to_reg: 2'b11,
              reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, valid: 1'b1};
    p = '0;
    e = '0;

    i_reset_n = 1'b1;
    ctrl(1'b1, 1'b0, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    drive(pat_a);
    tick();

    test_reset();
    test_load();
    test_back_to_back();
    test_stall_flush();
    test_freeze();
    test_bypass();
    test_async_reset_mid_stall();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
